// File: rtl/alu_result_writeback.sv
// Execute-stage result consumer: in-order FIFO retiring one result per cycle to the register file, with operand forwarding.
// Latency: stored results retire no earlier than the next cycle; with WB_BYPASS_EN defined, a result arriving at an idle, unstalled buffer is written the same cycle.
// Backpressure: ex_ready depends only on occupancy; wb_stall holds the head entry in place and never drops it.
module alu_result_writeback #(
    parameter int XLEN  = 32,
    parameter int REGW  = 5,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [REGW-1:0] ex_rd,
    input  logic            ex_ss,
    input  logic [XLEN-1:0] ex_result,
    input  logic            wb_stall,
    output logic            wb_we,
    output logic [REGW-1:0] wb_rd,
    output logic            wb_ss,
    output logic [XLEN-1:0] wb_data,
    input  logic [REGW-1:0] fwd_rs1,
    input  logic [REGW-1:0] fwd_rs2,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2,
    output logic            busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [REGW-1:0] rd;
        logic            ss;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [PW-1:0]   slot [DEPTH];

    logic accept;
    logic discard;
    logic bypass;
    logic push;
    logic pop;

    assign ex_ready = (count != CW'(DEPTH));
    assign busy     = (count != '0);
    assign accept   = ex_valid & ex_ready;
    // Scalar writes to x0 have no architectural effect, so they are swallowed here.
    assign discard  = (ex_rd == '0) & ~ex_ss;
    assign pop      = busy & ~wb_stall;

`ifdef WB_BYPASS_EN
    assign bypass = accept & ~discard & ~busy & ~wb_stall;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept & ~discard & ~bypass;

    // Write port: head entry by default, the incoming result when it bypasses the buffer.
    always_comb begin
        wb_we   = pop;
        wb_rd   = mem[rd_ptr].rd;
        wb_ss   = mem[rd_ptr].ss;
        wb_data = mem[rd_ptr].data;
        if (bypass) begin
            wb_we   = 1'b1;
            wb_rd   = ex_rd;
            wb_ss   = ex_ss;
            wb_data = ex_result;
        end
    end

    // Buffer slots ordered oldest (k=0) to youngest.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            slot[k] = rd_ptr + PW'(k);
        end
    end

    // Forwarding scan runs oldest to youngest so the youngest match is left standing.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[slot[k]] && (fwd_rs1 != '0) && (mem[slot[k]].rd == fwd_rs1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = mem[slot[k]].data;
            end
            if (vld[slot[k]] && (fwd_rs2 != '0) && (mem[slot[k]].rd == fwd_rs2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = mem[slot[k]].data;
            end
        end
    end

    // FIFO storage, pointers and occupancy; push and pop never touch the same slot in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{rd: ex_rd, ss: ex_ss, data: ex_result};
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Self-checking bench for alu_result_writeback: scoreboard of expected register-file writes plus per-scenario checks.
// Latency expectations follow the default build; WB_BYPASS_EN switches them to same-cycle writeback.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_alu_result_writeback;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_ss;
    logic [31:0] ex_result;
    logic        wb_stall;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic        wb_ss;
    logic [31:0] wb_data;
    logic [4:0]  fwd_rs1;
    logic [4:0]  fwd_rs2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [37:0] sb_q[$];

    alu_result_writeback #(.XLEN(32), .REGW(5), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_rd     (ex_rd),
        .ex_ss     (ex_ss),
        .ex_result (ex_result),
        .wb_stall  (wb_stall),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_ss     (wb_ss),
        .wb_data   (wb_data),
        .fwd_rs1   (fwd_rs1),
        .fwd_rs2   (fwd_rs2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    // Every register-file write must match the oldest expected entry.
    task automatic sb_monitor();
        logic [37:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && wb_we) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_write: rd=%0d ss=%b data=%h, required no write", wb_rd, wb_ss, wb_data);
                end else begin
                    exp = sb_q.pop_front();
                    if ({wb_rd, wb_ss, wb_data} !== exp) begin
                        errors++;
                        $display("FAIL sb_write: rd=%0d ss=%b data=%h, required rd=%0d ss=%b data=%h",
                                 wb_rd, wb_ss, wb_data, exp[37:33], exp[32], exp[31:0]);
                    end
                end
            end
        end
    endtask

    // Offer one result, wait (bounded) for ex_ready, record it if it should be written.
    task automatic push(input logic [4:0] rd, input logic ss, input logic [31:0] d);
        int n;
        n = 0;
        ex_rd = rd; ex_ss = ss; ex_result = d; ex_valid = 1'b1;
        while (!ex_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_ready_timeout: ex_ready=%b, required 1 within 20 cycles", ex_ready);
        end else if (!(rd == 5'd0 && !ss)) begin
            sb_q.push_back({rd, ss, d});
        end
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || sb_q.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: busy=%b pending=%0d, required busy=0 pending=0", busy, sb_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ex_valid = 1'b0; ex_rd = '0; ex_ss = 1'b0; ex_result = '0;
        wb_stall = 1'b0; fwd_rs1 = 5'd1; fwd_rs2 = 5'd2;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wb_we, busy, ex_ready, fwd_hit1, fwd_hit2} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_state: we/busy/ready/hit1/hit2=%b, required 00100", {wb_we, busy, ex_ready, fwd_hit1, fwd_hit2});
        end
        reset = 1'b0;
        @(posedge clk); #1;
        wb_stall = 1'b1;
        push(5'd3, 1'b0, 32'hA3);
        push(5'd4, 1'b0, 32'hA4);
        fwd_rs1 = 5'd3; fwd_rs2 = 5'd4;
        #1;
        checks++;
        if ({fwd_hit1, fwd_hit2, busy} !== 3'b111) begin
            errors++;
            $display("FAIL pending_before_reset: hit1/hit2/busy=%b, required 111", {fwd_hit1, fwd_hit2, busy});
        end
        #1;
        reset = 1'b1;
        sb_q.delete();
        #1;
        checks++;
        if ({wb_we, busy, ex_ready, fwd_hit1, fwd_hit2} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_midcycle: we/busy/ready/hit1/hit2=%b, required 00100", {wb_we, busy, ex_ready, fwd_hit1, fwd_hit2});
        end
        @(posedge clk); #1;
        reset = 1'b0; wb_stall = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        ex_rd = 5'd5; ex_ss = 1'b0; ex_result = 32'hDEADBEEF; ex_valid = 1'b1;
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: ex_ready=%b, required 1", ex_ready);
        end
        sb_q.push_back({5'd5, 1'b0, 32'hDEADBEEF});
        @(negedge clk);
        checks++;
`ifdef WB_BYPASS_EN
        if (wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEADBEEF || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_bypass: we=%b rd=%0d data=%h busy=%b, required 1 5 deadbeef 0", wb_we, wb_rd, wb_data, busy);
        end
`else
        if (wb_we !== 1'b0) begin
            errors++;
            $display("FAIL single_same_cycle: wb_we=%b, required 0", wb_we);
        end
`endif
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        checks++;
`ifdef WB_BYPASS_EN
        if (wb_we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after_bypass: we=%b busy=%b, required 0 0", wb_we, busy);
        end
`else
        if (wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_write: we=%b rd=%0d data=%h, required 1 5 deadbeef", wb_we, wb_rd, wb_data);
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_full_stall();
        wb_stall = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 1'b0, 32'(i * 16));
        fwd_rs1 = 5'd3; fwd_rs2 = 5'd9;
        #1;
        checks++;
        if (ex_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: ex_ready=%b, required 0", ex_ready);
        end
        checks++;
        if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h30 || fwd_hit2 !== 1'b0) begin
            errors++;
            $display("FAIL full_fwd: hit1=%b data1=%h hit2=%b, required 1 30 0", fwd_hit1, fwd_data1, fwd_hit2);
        end
        @(posedge clk); #1;
        wb_stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (wb_we !== 1'b1 || wb_rd !== 5'(i)) begin
                errors++;
                $display("FAIL drain_order: we=%b rd=%0d, required 1 %0d", wb_we, wb_rd, i);
            end
        end
        @(negedge clk);
        checks++;
        if (wb_we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_done: we=%b busy=%b, required 0 0", wb_we, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_discard();
        wb_stall = 1'b0;
        ex_rd = 5'd0; ex_ss = 1'b0; ex_result = 32'hFFFFFFFF; ex_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ex_ready !== 1'b1 || wb_we !== 1'b0) begin
            errors++;
            $display("FAIL discard_empty: ready=%b we=%b, required 1 0", ex_ready, wb_we);
        end
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL discard_empty_after: we=%b busy=%b, required 0 0", wb_we, busy);
        end
        @(posedge clk); #1;
        wb_stall = 1'b1;
        push(5'd9, 1'b0, 32'h99);
        push(5'd0, 1'b0, 32'hFFFFFFFF);
        checks++;
        if (busy !== 1'b1 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL discard_pending: busy=%b ready=%b, required 1 1", busy, ex_ready);
        end
        for (int i = 0; i < 3; i++) push(5'(20 + i), 1'b0, 32'(i));
        #1;
        checks++;
        if (ex_ready !== 1'b0) begin
            errors++;
            $display("FAIL discard_occupancy: ex_ready=%b after 4 stored, required 0", ex_ready);
        end
        wb_stall = 1'b0;
        wait_idle();
        wb_stall = 1'b1;
        push(5'd0, 1'b1, 32'h55);
        fwd_rs1 = 5'd0;
        #1;
        checks++;
        if (fwd_hit1 !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ss_rd0: hit1=%b busy=%b, required 0 1", fwd_hit1, busy);
        end
        wb_stall = 1'b0;
        wait_idle();
    endtask

    task automatic test_fwd_youngest();
        wb_stall = 1'b1;
        push(5'd7, 1'b0, 32'h11);
        push(5'd7, 1'b0, 32'h22);
        fwd_rs2 = 5'd7;
        #1;
        checks++;
        if (fwd_hit2 !== 1'b1 || fwd_data2 !== 32'h22) begin
            errors++;
            $display("FAIL fwd_youngest: hit2=%b data2=%h, required 1 22", fwd_hit2, fwd_data2);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (wb_we !== 1'b0 || wb_rd !== 5'd7 || wb_data !== 32'h11) begin
                errors++;
                $display("FAIL stall_hold: we=%b rd=%0d data=%h, required 0 7 11", wb_we, wb_rd, wb_data);
            end
        end
        @(posedge clk); #1;
        wb_stall = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_we !== 1'b1 || wb_data !== 32'h11) begin
            errors++;
            $display("FAIL fwd_drain1: we=%b data=%h, required 1 11", wb_we, wb_data);
        end
        @(negedge clk);
        checks++;
        if (wb_we !== 1'b1 || wb_data !== 32'h22) begin
            errors++;
            $display("FAIL fwd_drain2: we=%b data=%h, required 1 22", wb_we, wb_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_retire();
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) push(5'(10 + i), 1'b0, 32'(256 + i));
        #1;
        checks++;
        if (ex_ready !== 1'b0) begin
            errors++;
            $display("FAIL fr_full: ex_ready=%b, required 0", ex_ready);
        end
        @(posedge clk); #1;
        wb_stall = 1'b0;
        ex_rd = 5'd14; ex_ss = 1'b0; ex_result = 32'hE0E0; ex_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ex_ready !== 1'b0 || wb_we !== 1'b1) begin
            errors++;
            $display("FAIL fr_retire: ready=%b we=%b, required 0 1", ex_ready, wb_we);
        end
        @(posedge clk); #1;
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL fr_ready_next: ex_ready=%b, required 1", ex_ready);
        end
        sb_q.push_back({5'd14, 1'b0, 32'hE0E0});
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        sb_q.delete();
        #1;
        checks++;
        if (wb_we !== 1'b0 || busy !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL fr_reset: we=%b busy=%b ready=%b, required 0 0 1", wb_we, busy, ex_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (wb_we !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL fr_post_reset: we=%b busy=%b, required 0 0", wb_we, busy);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_single();
        test_full_stall();
        test_discard();
        test_fwd_youngest();
        test_full_retire();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: pending=%0d, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
